// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default 27 MHz timing constants for the PLL
// lock sequencer.
`timescale 1ns/1ps
package pll_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_t;

    localparam int DEF_RST_CYCLES    = 27;
    localparam int DEF_LOCK_TIMEOUT  = 27000;
    localparam int DEF_STABLE_CYCLES = 270;
    localparam int DEF_MAX_RETRY     = 7;
    localparam int DEF_SYNC_STAGES   = 2;

    localparam logic [3:0] RETRY_SAT = 4'd15;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low clear;
// used for the PLL lock input and for reset deassertion.
`timescale 1ns/1ps
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up the system PLL: pulses its reset, qualifies lock over a stability
// window, then releases the downstream reset; retries on timeout, resequences on loss.
`timescale 1ns/1ps
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int MAX_CNT = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    logic lock_s;
    logic rst_sync_n;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    sync_bit #(.STAGES(2)) u_rst_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (1'b1),
        .q     (rst_sync_n)
    );

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d, retry_inc;
    logic             pll_reset_q, pll_reset_d;
    logic             sys_rst_n_q, sys_rst_n_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    // One shared counter serves the reset pulse, the lock timeout and the
    // stability window; it is cleared on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 4'd1;

        if (rst_sync_n) begin
            if (force_relock && (state_q != PLL_RST)) begin
                state_d = PLL_RST;
                cnt_d   = '0;
                retry_d = '0;
            end else begin
                case (state_q)
                    PLL_RST: begin
                        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                            state_d = WAIT_LOCK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state_d = STABLE;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            cnt_d   = '0;
                            retry_d = retry_inc;
                            if ((MAX_RETRY != 0) && (int'(retry_inc) == MAX_RETRY)) begin
                                state_d = FAIL;
                            end else begin
                                state_d = PLL_RST;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    STABLE: begin
                        if (!lock_s) begin
                            state_d = WAIT_LOCK;
                            cnt_d   = '0;
                        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                            state_d = RUN;
                            cnt_d   = '0;
                            retry_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (!lock_s) begin
                            state_d = PLL_RST;
                            cnt_d   = '0;
                        end
                    end
                    FAIL: begin
                        state_d = FAIL;
                    end
                    default: begin
                        state_d = PLL_RST;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        pll_reset_d = (state_d == PLL_RST);
        sys_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
        fail_d      = (state_d == FAIL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_reset = pll_reset_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign state     = state_q;

endmodule
